pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register that generalises the EX->MEM boundary register. It carries a packed control field, two data words and a destination register index through one pipeline stage. It adds a valid/ready handshake with an optional 2-entry skid buffer, a synchronous flush that inserts bubbles, and bubble-safe control outputs. It can be placed at any stage boundary of the core (ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 32, width of each data word (alu and wdata)
REG_W, 5, width of destination register index
CTRL_W, 3, width of packed control field; bit0 regWrite, bit1 memToReg, bit2 memWrite
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept payload this cycle
in_ctrl  input  CTRL_W  upstream control field
in_alu  input  DATA_W  upstream ALU result
in_wdata  input  DATA_W  upstream store data
in_wreg  input  REG_W  upstream destination register
flush  input  1  synchronous kill of all held entries
out_valid  output  1  output payload valid
out_ready  input  1  downstream accepts payload
out_ctrl  output  CTRL_W  control field, forced 0 when out_valid=0
out_alu  output  DATA_W  held ALU result
out_wdata  output  DATA_W  held store data
out_wreg  output  REG_W  held destination register
level  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset is asynchronous, active-low, on clk and rst as already decided. While rst=0:
  - main and skid valid flags = 0, so out_valid=0 and level=0.
  - All payload registers = 0, so out_ctrl, out_alu, out_wdata and out_wreg = 0.
  - in_ready = 1 in the first cycle after release, unless flush is high.
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: a payload accepted at edge N is presented at the outputs after edge N (1 cycle).
- Order is strictly preserved and no payload is duplicated.
- SKID=1, in_ready:
  - in_ready is registered and equals !skid_valid.
  - in_ready is forced to 0 combinationally while flush=1.
- SKID=1, main entry update, per edge:
  - If main is empty or out_fire: main loads skid if skid_valid, else loads the input if in_fire, else main_valid goes to 0.
  - A skid-to-main transfer clears skid, unless in_fire in the same cycle; then the input lands in skid.
  - If main is valid, !out_fire and in_fire: the input is written into skid.
- SKID=0: in_ready = (!main_valid | out_ready) & !flush, combinational. Only the main entry exists.
- Simultaneous in_fire and out_fire with main full and skid empty: main takes the input and level stays 1 (full throughput).
- Full: level=2 and out_ready=0. in_ready=0; all state holds; payload is stable.
- Empty: out_valid=0. out_ctrl=0 regardless of stale data; data outputs hold their last value.
- flush=1 at an edge:
  - Both valid flags are cleared and level becomes 0.
  - Nothing is accepted that cycle; in_ready is already 0.
  - Payload data registers need not clear; out_ctrl is 0 through the valid masking.
- flush has priority over out_ready; a downstream handshake in a flush cycle is still counted by downstream, because out_valid was 1 before the edge.
- Reset mid-operation: all held entries are discarded immediately, asynchronously, with no partial update.
- level = main_valid + skid_valid, registered, so it updates with the state.
- out_* are driven directly from the main registers (no combinational path from in_* to out_*).
- The only combinational paths are from flush, or from out_ready when SKID=0, to in_ready.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL bit-index constants: REGWRITE=0, MEMTOREG=1, MEMWRITE=2.
  - Default widths: DATA_W=32, REG_W=5, CTRL_W=3.
  - The packed payload width PAYLOAD_W = CTRL_W+2*DATA_W+REG_W.
- Payload is packed into one PAYLOAD_W vector internally.
- One natural sub-module, pipe_entry: a single valid+payload register with load/clear enables and async active-low reset. It is instantiated once for main and once for skid (skid only when SKID=1).

Test Plan:
- Reset: hold rst=0 with in_valid=1 and in_ctrl=3'b111 -> out_valid=0, out_ctrl=0, out_alu=0, level=0; one cycle after release in_ready=1.
- Streaming: out_ready=1, present 0x11, 0x22, 0x33 on in_alu on consecutive cycles -> each appears on out_alu one cycle later, in order, out_valid=1 continuously, level=1.
- Backpressure (SKID=1): out_ready=0, send 0xA then 0xB -> level=2, in_ready=0, 0xC is held off upstream. Raise out_ready -> outputs 0xA, 0xB, 0xC in order, no loss.
- Flush: with level=2 (ctrl=3'b101), assert flush one cycle -> next cycle out_valid=0, out_ctrl=0, level=0. The in_valid beat in the flush cycle is not accepted (in_ready=0).
- Bubble masking: after the last payload drains (out_valid=0) -> out_ctrl=0 while out_alu keeps its last value. Downstream regWrite/memWrite never assert.
- SKID=0 build: out_ready=0 with main full -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> swap each cycle at full throughput, level never exceeds 1.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared widths, control-bit indices and payload packing helpers for pipeline stage registers.
package pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 3;

  localparam int unsigned REGWRITE = 0;
  localparam int unsigned MEMTOREG = 1;
  localparam int unsigned MEMWRITE = 2;

  localparam int unsigned PAYLOAD_W = CTRL_W + 2 * DATA_W + REG_W;

  // Packed payload layout is {ctrl, alu, wdata, wreg}, ctrl in the MSBs.
  function automatic int unsigned payload_w(input int unsigned ctrl_w,
                                            input int unsigned data_w,
                                            input int unsigned reg_w);
    return ctrl_w + 2 * data_w + reg_w;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_entry.sv
// One pipeline slot: a valid flag plus a packed payload register with load/clear enables.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned W = PAYLOAD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // clear wins over load; payload is left untouched on clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer, flush and bubble-masked control.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned REG_W  = pipe_pkg::REG_W,
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_W-1:0]  in_wreg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [REG_W-1:0]  out_wreg,
  output logic [1:0]        level
);

  localparam int unsigned PW       = payload_w(CTRL_W, DATA_W, REG_W);
  localparam bit          HAS_SKID = (SKID != 0);

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          main_valid;
  logic          skid_valid;
  logic          main_load;
  logic          main_clear;
  logic          skid_load;
  logic          skid_clear;
  logic          in_fire;
  logic          out_fire;
  logic          main_v_nxt;
  logic          skid_v_nxt;
  logic [1:0]    level_q;

  assign in_payload = {in_ctrl, in_alu, in_wdata, in_wreg};
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = main_valid & out_ready;

  // Only flush (and out_ready without a skid slot) reach in_ready combinationally.
  always_comb begin
    in_ready = 1'b0;
    if (HAS_SKID) in_ready = ~skid_valid & ~flush;
    else          in_ready = (~main_valid | out_ready) & ~flush;
  end

  // Entry steering: skid drains into main first, so order is preserved.
  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_d     = in_payload;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!main_valid || out_fire) begin
      if (skid_valid) begin
        main_load = 1'b1;
        main_d    = skid_q;
        if (in_fire) skid_load  = 1'b1;
        else         skid_clear = 1'b1;
      end else if (in_fire) begin
        main_load = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else if (in_fire) begin
      skid_load = 1'b1;
    end
  end

  always_comb begin
    main_v_nxt = main_valid;
    skid_v_nxt = skid_valid;
    if (main_clear)     main_v_nxt = 1'b0;
    else if (main_load) main_v_nxt = 1'b1;
    if (skid_clear)     skid_v_nxt = 1'b0;
    else if (skid_load) skid_v_nxt = HAS_SKID;
  end

  // Occupancy is registered alongside the entries it counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) level_q <= 2'd0;
    else      level_q <= 2'(main_v_nxt) + 2'(skid_v_nxt);
  end

  pipe_entry #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  if (HAS_SKID) begin : g_skid
    pipe_entry #(.W(PW)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_payload),
      .valid (skid_valid),
      .q     (skid_q)
    );
  end else begin : g_noskid
    logic unused_skid_ctl;
    assign unused_skid_ctl = skid_clear;
    assign skid_valid      = 1'b0;
    assign skid_q          = '0;
  end

  // Bubbles present a zero control field so downstream never writes.
  assign out_valid = main_valid;
  assign out_ctrl  = main_q[PW-1 -: CTRL_W] & {CTRL_W{main_valid}};
  assign out_alu   = main_q[2*DATA_W+REG_W-1 -: DATA_W];
  assign out_wdata = main_q[DATA_W+REG_W-1 -: DATA_W];
  assign out_wreg  = main_q[REG_W-1:0];
  assign level     = level_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg: one instance with skid buffer, one without.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [2:0]  in_ctrl, out_ctrl;
  logic [31:0] in_alu, in_wdata, out_alu, out_wdata;
  logic [4:0]  in_wreg, out_wreg;
  logic [1:0]  level;

  logic        s0_in_valid, s0_in_ready, s0_flush, s0_out_valid, s0_out_ready;
  logic [2:0]  s0_in_ctrl, s0_out_ctrl;
  logic [31:0] s0_in_alu, s0_in_wdata, s0_out_alu, s0_out_wdata;
  logic [4:0]  s0_in_wreg, s0_out_wreg;
  logic [1:0]  s0_level;

  int checks;
  int errors;

  pipe_skid_reg #(.SKID(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_alu(in_alu), .in_wdata(in_wdata), .in_wreg(in_wreg),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_alu(out_alu), .out_wdata(out_wdata), .out_wreg(out_wreg),
    .level(level)
  );

  pipe_skid_reg #(.SKID(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_ctrl(s0_in_ctrl),
    .in_alu(s0_in_alu), .in_wdata(s0_in_wdata), .in_wreg(s0_in_wreg),
    .flush(s0_flush),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_ctrl(s0_out_ctrl),
    .out_alu(s0_out_alu), .out_wdata(s0_out_wdata), .out_wreg(s0_out_wreg),
    .level(s0_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1; in_ctrl = 3'b111; in_alu = 32'hDEAD; in_wdata = 32'h1; in_wreg = 5'd3;
    out_ready = 1'b0; flush = 1'b0;
    s0_in_valid = 1'b1; s0_in_ctrl = 3'b111; s0_in_alu = 32'hBEEF; s0_in_wdata = '0; s0_in_wreg = '0;
    s0_out_ready = 1'b0; s0_flush = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_ctrl !== 3'b000) begin errors++; $display("FAIL reset_out_ctrl got %b exp 000", out_ctrl); end
    checks++; if (out_alu !== 32'h0) begin errors++; $display("FAIL reset_out_alu got %h exp 0", out_alu); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (s0_level !== 2'd0 || s0_out_valid !== 1'b0) begin errors++; $display("FAIL reset_s0 got lvl %0d v %b exp 0 0", s0_level, s0_out_valid); end
    in_valid = 1'b0; s0_in_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = 3'b001; in_alu = vals[i]; in_wdata = vals[i] + 32'h100; in_wreg = 5'(i + 1);
      step();
      checks++; if (out_alu !== vals[i]) begin errors++; $display("FAIL stream_alu[%0d] got %h exp %h", i, out_alu, vals[i]); end
      checks++; if (out_valid !== 1'b1 || level !== 2'd1) begin errors++; $display("FAIL stream_vl[%0d] got v %b lvl %0d exp 1 1", i, out_valid, level); end
      checks++; if (out_wreg !== 5'(i + 1) || out_ctrl !== 3'b001) begin errors++; $display("FAIL stream_meta[%0d] got reg %0d ctrl %b exp %0d 001", i, out_wreg, out_ctrl, i + 1); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bubble();
    step();
    checks++; if (out_valid !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL bubble_vl got v %b lvl %0d exp 0 0", out_valid, level); end
    checks++; if (out_ctrl !== 3'b000) begin errors++; $display("FAIL bubble_ctrl got %b exp 000", out_ctrl); end
    checks++; if (out_alu !== 32'h33) begin errors++; $display("FAIL bubble_alu_hold got %h exp 33", out_alu); end
    checks++; if (out_wdata !== 32'h133) begin errors++; $display("FAIL bubble_wdata_hold got %h exp 133", out_wdata); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 3'b101; in_alu = 32'hA;
    step();
    checks++; if (out_alu !== 32'hA || level !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_first got alu %h lvl %0d rdy %b exp a 1 1", out_alu, level, in_ready); end
    in_alu = 32'hB;
    step();
    checks++; if (level !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got lvl %0d rdy %b exp 2 0", level, in_ready); end
    checks++; if (out_alu !== 32'hA) begin errors++; $display("FAIL bp_full_alu got %h exp a", out_alu); end
    in_alu = 32'hC;
    step();
    checks++; if (level !== 2'd2 || in_ready !== 1'b0 || out_alu !== 32'hA) begin errors++; $display("FAIL bp_hold got lvl %0d rdy %b alu %h exp 2 0 a", level, in_ready, out_alu); end
    out_ready = 1'b1;
    step();
    checks++; if (out_alu !== 32'hB || level !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_b got alu %h lvl %0d rdy %b exp b 1 1", out_alu, level, in_ready); end
    step();
    checks++; if (out_alu !== 32'hC || level !== 2'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_c got alu %h lvl %0d v %b exp c 1 1", out_alu, level, out_valid); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL bp_empty got v %b lvl %0d exp 0 0", out_valid, level); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 3'b101; in_alu = 32'hD1;
    step();
    in_alu = 32'hD2;
    step();
    checks++; if (level !== 2'd2 || out_ctrl !== 3'b101) begin errors++; $display("FAIL flush_pre got lvl %0d ctrl %b exp 2 101", level, out_ctrl); end
    flush = 1'b1; in_alu = 32'hEE; skid_free_probe();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 3'b000 || level !== 2'd0) begin errors++; $display("FAIL flush_post got v %b ctrl %b lvl %0d exp 0 000 0", out_valid, out_ctrl, level); end
    step();
    checks++; if (out_valid !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL flush_no_accept got v %b lvl %0d exp 0 0", out_valid, level); end
  endtask

  // Keeps in_valid asserted through the flush cycle so a wrongly accepted beat would show up.
  task automatic skid_free_probe();
    in_valid = 1'b1;
  endtask

  task automatic test_skid0();
    s0_out_ready = 1'b0;
    s0_in_valid = 1'b1; s0_in_ctrl = 3'b011; s0_in_alu = 32'h5;
    step();
    checks++; if (s0_out_alu !== 32'h5 || s0_level !== 2'd1) begin errors++; $display("FAIL s0_load got alu %h lvl %0d exp 5 1", s0_out_alu, s0_level); end
    checks++; if (s0_in_ready !== 1'b0) begin errors++; $display("FAIL s0_full_rdy got %b exp 0", s0_in_ready); end
    step();
    checks++; if (s0_out_alu !== 32'h5 || s0_level !== 2'd1) begin errors++; $display("FAIL s0_stall got alu %h lvl %0d exp 5 1", s0_out_alu, s0_level); end
    s0_out_ready = 1'b1; s0_in_alu = 32'h6;
    #1;
    checks++; if (s0_in_ready !== 1'b1) begin errors++; $display("FAIL s0_comb_rdy got %b exp 1", s0_in_ready); end
    step();
    checks++; if (s0_out_alu !== 32'h6 || s0_level !== 2'd1) begin errors++; $display("FAIL s0_swap6 got alu %h lvl %0d exp 6 1", s0_out_alu, s0_level); end
    s0_in_alu = 32'h7;
    step();
    checks++; if (s0_out_alu !== 32'h7 || s0_level !== 2'd1 || s0_out_valid !== 1'b1) begin errors++; $display("FAIL s0_swap7 got alu %h lvl %0d v %b exp 7 1 1", s0_out_alu, s0_level, s0_out_valid); end
    s0_flush = 1'b1;
    #1;
    checks++; if (s0_in_ready !== 1'b0) begin errors++; $display("FAIL s0_flush_rdy got %b exp 0", s0_in_ready); end
    step();
    s0_flush = 1'b0; s0_in_valid = 1'b0;
    #1;
    checks++; if (s0_out_valid !== 1'b0 || s0_out_ctrl !== 3'b000 || s0_level !== 2'd0) begin errors++; $display("FAIL s0_flush_post got v %b ctrl %b lvl %0d exp 0 000 0", s0_out_valid, s0_out_ctrl, s0_level); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_bubble();
    test_backpressure();
    test_flush();
    test_skid0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
